// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 scancode receiver
package ps2_pkg;

    // Prefix bytes that modify the next scancode instead of producing an event
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // One decoded key event as stored in the event queue
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    // Frame receiver states; IDLE waits for a start bit
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - event queue with valid/ready read side and full/empty flags
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    input  ps2_event_t wr_data,
    input  logic       rd_ready,
    output ps2_event_t rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    ps2_event_t  mem_q [DEPTH];
    logic        pop;
    logic        push;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = ~empty & rd_ready;
    // A full queue still accepts a write when the head leaves in the same cycle
    assign push    = wr_valid & (~full | pop);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance on accepted push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; contents are only visible when not empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 keyboard receiver producing scancode events
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int FIFO_DEPTH     = 8,
    parameter int HISTORY_BYTES  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       kclk,
    input  logic                       kdata,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [7:0]                 evt_code,
    output logic                       evt_ext,
    output logic                       evt_brk,
    output logic [8*HISTORY_BYTES-1:0] keycodeout,
    output logic                       byte_strobe,
    output logic                       parity_err,
    output logic                       frame_err,
    output logic                       overflow,
    input  logic                       clr_overflow
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int KW  = 8 * HISTORY_BYTES;

    // Input conditioning: index 0 is kclk, index 1 is kdata
    logic [1:0]     sync1_q, sync2_q;
    logic [1:0]     filt_q, filt_d;
    logic [FCW-1:0] fcnt_q [2];
    logic [FCW-1:0] fcnt_d [2];
    logic           kclk_prev_q;
    logic           kclk_f, kdata_f, fall;

    // Frame receiver
    ps2_state_t     state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_acc_q, par_acc_d;
    logic           par_bad_q, par_bad_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic           timeout_hit;
    logic [KW-1:0]  keycode_q, keycode_d;
    logic           byte_strobe_q, byte_strobe_d;
    logic           parity_err_q, parity_err_d;
    logic           frame_err_q, frame_err_d;

    // Event path
    logic           ext_pend_q, ext_pend_d;
    logic           brk_pend_q, brk_pend_d;
    logic           overflow_q, overflow_d;
    logic           evt_wr;
    logic [7:0]     new_byte;
    ps2_event_t     evt_wdata, evt_head;
    logic           fifo_full, fifo_empty;

    // Glitch filter: a level flips only after FILTER_LEN consecutive differing samples
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            fcnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FCW'(FILTER_LEN - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + FCW'(1);
                end
            end
        end
    end

    // Synchronisers, filter state and edge history; idle bus level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            filt_q      <= 2'b11;
            fcnt_q[0]   <= '0;
            fcnt_q[1]   <= '0;
            kclk_prev_q <= 1'b1;
        end else begin
            sync1_q     <= {kdata, kclk};
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            fcnt_q[0]   <= fcnt_d[0];
            fcnt_q[1]   <= fcnt_d[1];
            kclk_prev_q <= filt_q[0];
        end
    end

    assign kclk_f      = filt_q[0];
    assign kdata_f     = filt_q[1];
    assign fall        = kclk_prev_q & ~kclk_f;
    assign timeout_hit = (state_q != ST_IDLE) && !fall &&
                         (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: advance only on filtered kclk falling edges
    always_comb begin
        state_d = state_q;
        if (timeout_hit) begin
            state_d = ST_IDLE;
        end else if (fall) begin
            unique case (state_q)
                ST_IDLE:   if (!kdata_f) state_d = ST_DATA;
                ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: bit shifting, parity tracking, timeout count and status pulses
    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_acc_d     = par_acc_q;
        par_bad_d     = par_bad_q;
        keycode_d     = keycode_q;
        byte_strobe_d = 1'b0;
        parity_err_d  = 1'b0;
        frame_err_d   = 1'b0;
        to_cnt_d      = (state_q == ST_IDLE || fall) ? '0 : to_cnt_q + TW'(1);
        if (timeout_hit) begin
            frame_err_d = 1'b1;
            to_cnt_d    = '0;
        end else if (fall) begin
            unique case (state_q)
                ST_IDLE: begin
                    bit_cnt_d = 3'd0;
                    par_acc_d = 1'b0;
                    par_bad_d = 1'b0;
                end
                ST_DATA: begin
                    shift_d   = {kdata_f, shift_q[7:1]};
                    par_acc_d = par_acc_q ^ kdata_f;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                ST_PARITY: begin
                    // Odd parity: data bits XOR parity bit must be 1
                    par_bad_d    = ~(par_acc_q ^ kdata_f);
                    parity_err_d = ~(par_acc_q ^ kdata_f);
                end
                ST_STOP: begin
                    if (!kdata_f) begin
                        frame_err_d = 1'b1;
                    end else if (!par_bad_q) begin
                        byte_strobe_d = 1'b1;
                        keycode_d     = (keycode_q << 8) | KW'(shift_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // Receiver datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_acc_q     <= 1'b0;
            par_bad_q     <= 1'b0;
            to_cnt_q      <= '0;
            keycode_q     <= '0;
            byte_strobe_q <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_acc_q     <= par_acc_d;
            par_bad_q     <= par_bad_d;
            to_cnt_q      <= to_cnt_d;
            keycode_q     <= keycode_d;
            byte_strobe_q <= byte_strobe_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Prefix bytes arm pending flags; any other byte becomes an event and consumes them
    always_comb begin
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        evt_wr     = 1'b0;
        if (byte_strobe_q) begin
            if (new_byte == PS2_EXT) begin
                ext_pend_d = 1'b1;
            end else if (new_byte == PS2_BRK) begin
                brk_pend_d = 1'b1;
            end else begin
                evt_wr     = 1'b1;
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end
    end

    // Sticky overflow; a new drop wins over a same-cycle clear
    always_comb begin
        overflow_d = overflow_q;
        if (evt_wr && fifo_full && !(evt_ready && !fifo_empty)) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Pending flags and overflow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            overflow_q <= overflow_d;
        end
    end

    assign new_byte       = keycode_q[7:0];
    assign evt_wdata.ext  = ext_pend_q;
    assign evt_wdata.brk  = brk_pend_q;
    assign evt_wdata.code = new_byte;

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (evt_wr),
        .wr_data  (evt_wdata),
        .rd_ready (evt_ready),
        .rd_data  (evt_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign evt_valid   = ~fifo_empty;
    assign evt_code    = evt_valid ? evt_head.code : 8'h00;
    assign evt_ext     = evt_valid & evt_head.ext;
    assign evt_brk     = evt_valid & evt_head.brk;
    assign keycodeout  = keycode_q;
    assign byte_strobe = byte_strobe_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overflow    = overflow_q;

endmodule
